// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one register-to-register instruction at a time to the
// 16-bit logic unit and writes the result back into an internal register file.
// Flow is IDLE -> EXEC -> WB -> IDLE. MOV, LDI and illegal opcodes finish in
// EXEC. done/err are registered, so they pulse in the IDLE cycle after retire.
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [WIDTH-1:0] imm,
  output logic [10:0]      op_strobe,
  output logic             passthrough,
  output logic             push,
  output logic             push_high,
  output logic [WIDTH-1:0] bus1,
  output logic [WIDTH-1:0] bus2,
  input  logic [WIDTH-1:0] bus3,
  input  logic [WIDTH-1:0] bus4,
  output logic             done,
  output logic             err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_LAST_ALU = 4'd10;
  localparam logic [3:0] OP_MUL      = 4'd4;
  localparam logic [3:0] OP_MOV      = 4'd11;
  localparam logic [3:0] OP_LDI      = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    rd_hi;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] bus1_q, bus1_d, bus2_q, bus2_d;
  logic             done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // MUL high word lands in the next register; AW-bit add wraps 7 -> 0.
  assign rd_hi       = rd_q + 1'b1;
  assign instr_ready = (state_q == S_IDLE);
  assign bus1        = bus1_q;
  assign bus2        = bus2_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_data    = regs_q[dbg_addr];

  // Next-state, logic-unit controls and register-file writeback.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    bus1_d      = bus1_q;
    bus2_d      = bus2_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    regs_d      = regs_q;
    op_strobe   = '0;
    passthrough = 1'b0;
    push        = 1'b0;
    push_high   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          rd_d    = rd;
          imm_d   = imm;
          // Operands are captured on the accept edge, so they are stable
          // for the whole EXEC cycle even if rd aliases rs1/rs2.
          bus1_d  = regs_q[rs1];
          bus2_d  = regs_q[rs2];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q <= OP_LAST_ALU) begin
          op_strobe = 11'(1) << op_q;
          state_d   = S_WB;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (op_q == OP_MOV) begin
            passthrough  = 1'b1;
            regs_d[rd_q] = bus3;
          end else if (op_q == OP_LDI) begin
            regs_d[rd_q] = imm_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WB: begin
        push         = 1'b1;
        regs_d[rd_q] = bus3;
        if (op_q == OP_MUL) begin
          push_high     = 1'b1;
          regs_d[rd_hi] = bus4;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched instruction fields, operand buses and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      bus1_q  <= '0;
      bus2_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      bus1_q  <= bus1_d;
      bus2_q  <= bus2_d;
      done_q  <= done_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small logic-unit stub answers the strobes, and an
// architectural register-file model predicts every register after each retire.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [15:0] imm = '0;
  logic [10:0] op_strobe;
  logic        passthrough, push, push_high;
  logic [15:0] bus1, bus2, bus3, bus4;
  logic        done, err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  logic [15:0] m [8];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .op_strobe(op_strobe), .passthrough(passthrough), .push(push), .push_high(push_high),
    .bus1(bus1), .bus2(bus2), .bus3(bus3), .bus4(bus4), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Operation semantics of the logic unit (shift amount is b[3:0]).
  function automatic logic [31:0] alu_fn(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a + 16'd1;
      3: r = a - 16'd1;
      4: return 32'(a) * 32'(b);
      5: r = a >> b[3:0];
      6: r = a << b[3:0];
      7: r = a & b;
      8: r = a | b;
      9: r = a ^ b;
      10: r = ~a;
      default: r = '0;
    endcase
    return {16'h0, r};
  endfunction

  // Logic-unit stub: latches the result on the strobe edge, passes bus1 on MOV.
  logic [31:0] lu_q = '0;
  always @(posedge clk)
    for (int i = 0; i < 11; i++)
      if (op_strobe[i]) lu_q <= alu_fn(i, bus1, bus2);
  assign bus3 = passthrough ? bus1 : lu_q[15:0];
  assign bus4 = lu_q[31:16];

  // Architectural effect of one instruction on the model register file.
  task automatic model_apply(input logic [3:0] op, input logic [2:0] d, s1, s2, input logic [15:0] im);
    logic [31:0] r;
    if (op <= 4'd10) begin
      r = alu_fn(int'(op), m[s1], m[s2]);
      m[d] = r[15:0];
      if (op == 4'd4) m[3'(d + 3'd1)] = r[31:16];
    end else if (op == 4'd11) m[d] = m[s1];
    else if (op == 4'd12) m[d] = im;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      nvec++;
      if (dbg_data !== m[i]) begin
        nerr++;
        $display("FAIL %s reg%0d: got %h expected %h", tag, i, dbg_data, m[i]);
      end
    end
  endtask

  task automatic check_dbg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    nvec++;
    if (dbg_data !== exp) begin
      nerr++;
      $display("FAIL %s r%0d: got %h expected %h", tag, a, dbg_data, exp);
    end
  endtask

  // One instruction from idle to retire, checking every cycle's controls.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] d, s1, s2, input logic [15:0] im);
    logic [10:0] es;
    @(negedge clk);
    nvec++;
    if (instr_ready !== 1'b1) begin
      nerr++; $display("FAIL ready_idle: got %b expected 1", instr_ready);
    end
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    es = (op <= 4'd10) ? (11'(1) << op) : 11'd0;
    nvec++;
    if (op_strobe !== es || passthrough !== (op == 4'd11) || push !== 1'b0 ||
        push_high !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b0) begin
      nerr++;
      $display("FAIL exec_ctl op%0d: strobe=%h pt=%b push=%b ph=%b done=%b rdy=%b expected strobe=%h pt=%b",
               op, op_strobe, passthrough, push, push_high, done, instr_ready, es, op == 4'd11);
    end
    nvec++;
    if (bus1 !== m[s1] || bus2 !== m[s2]) begin
      nerr++;
      $display("FAIL exec_bus op%0d: bus1=%h bus2=%h expected %h %h", op, bus1, bus2, m[s1], m[s2]);
    end
    model_apply(op, d, s1, s2, im);
    if (op <= 4'd10) begin
      @(negedge clk);
      nvec++;
      if (push !== 1'b1 || push_high !== (op == 4'd4) || op_strobe !== 11'd0 ||
          passthrough !== 1'b0 || done !== 1'b0) begin
        nerr++;
        $display("FAIL wb_ctl op%0d: push=%b ph=%b strobe=%h pt=%b done=%b expected push=1 ph=%b",
                 op, push, push_high, op_strobe, passthrough, done, op == 4'd4);
      end
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b1 || err !== (op >= 4'd13) || instr_ready !== 1'b1 ||
        push !== 1'b0 || push_high !== 1'b0 || op_strobe !== 11'd0 || passthrough !== 1'b0) begin
      nerr++;
      $display("FAIL retire op%0d: done=%b err=%b rdy=%b push=%b strobe=%h expected done=1 err=%b",
               op, done, err, instr_ready, push, op_strobe, op >= 4'd13);
    end
    check_regs("regs_after_retire");
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) m[i] = '0;
    #1;
    nvec++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || push !== 1'b0 ||
        push_high !== 1'b0 || op_strobe !== 11'd0 || passthrough !== 1'b0 ||
        bus1 !== 16'd0 || bus2 !== 16'd0) begin
      nerr++;
      $display("FAIL reset_outputs: rdy=%b done=%b err=%b push=%b strobe=%h bus1=%h bus2=%h",
               instr_ready, done, err, push, op_strobe, bus1, bus2);
    end
    check_regs("reset_regs");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    run_instr(4'd12, 3'd1, 3'd0, 3'd0, 16'h1234);
    run_instr(4'd12, 3'd2, 3'd0, 3'd0, 16'h0F0F);
    run_instr(4'd0, 3'd3, 3'd1, 3'd2, 16'h0);
    check_dbg("add_result", 3'd3, 16'h2143);
  endtask

  task automatic test_sub_shl;
    run_instr(4'd12, 3'd6, 3'd0, 3'd0, 16'h0001);
    run_instr(4'd1, 3'd4, 3'd0, 3'd6, 16'h0);
    check_dbg("sub_result", 3'd4, 16'hFFFF);
    run_instr(4'd12, 3'd2, 3'd0, 3'd0, 16'h0004);
    run_instr(4'd6, 3'd5, 3'd4, 3'd2, 16'h0);
    check_dbg("shl_result", 3'd5, 16'hFFF0);
  endtask

  task automatic test_mul_wrap;
    run_instr(4'd12, 3'd6, 3'd0, 3'd0, 16'h0100);
    run_instr(4'd4, 3'd7, 3'd6, 3'd6, 16'h0);
    check_dbg("mul_lo", 3'd7, 16'h0000);
    check_dbg("mul_hi_wrap", 3'd0, 16'h0001);
  endtask

  task automatic test_illegal;
    run_instr(4'd14, 3'd3, 3'd1, 3'd2, 16'hBEEF);
    run_instr(4'd13, 3'd0, 3'd0, 3'd0, 16'h5555);
    run_instr(4'd15, 3'd7, 3'd7, 3'd7, 16'hAAAA);
  endtask

  task automatic test_reset_mid_wb;
    @(negedge clk);
    opcode = 4'd0; rd = 3'd5; rs1 = 3'd1; rs2 = 3'd2; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if (push !== 1'b1) begin
      nerr++; $display("FAIL pre_reset_push: got %b expected 1", push);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (push !== 1'b0 || instr_ready !== 1'b1 || done !== 1'b0 || op_strobe !== 11'd0) begin
      nerr++;
      $display("FAIL reset_mid_wb: push=%b rdy=%b done=%b strobe=%h expected 0 1 0 0",
               push, instr_ready, done, op_strobe);
    end
    for (int i = 0; i < 8; i++) m[i] = '0;
    check_regs("reset_mid_wb_regs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || push !== 1'b0) begin
      nerr++; $display("FAIL after_reset_quiet: done=%b push=%b expected 0 0", done, push);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) run_instr(4'd12, 3'(i), 3'd0, 3'd0, 16'($urandom));
    for (int n = 0; n < 40; n++)
      run_instr(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
  endtask

  task automatic test_back_to_back;
    logic [3:0]  q_op  [4] = '{4'd12, 4'd0, 4'd11, 4'd9};
    logic [2:0]  q_rd  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0]  q_rs1 [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0]  q_rs2 [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [15:0] q_imm [4] = '{16'h00AA, 16'h0, 16'h0, 16'h0};
    int k = 0, dones = 0, cyc = 0, extra = 0;
    logic rdy_prev = 1'b0;
    while ((k < 4 || dones < 4) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (instr_valid && rdy_prev) k++;
      if (done) dones++;
      if (k < 4) begin
        opcode = q_op[k]; rd = q_rd[k]; rs1 = q_rs1[k]; rs2 = q_rs2[k]; imm = q_imm[k];
        instr_valid = 1'b1;
      end else instr_valid = 1'b0;
      rdy_prev = instr_ready;
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    nvec++;
    if (k != 4 || dones != 4 || extra != 0) begin
      nerr++;
      $display("FAIL b2b_counts: accepts=%0d dones=%0d extra=%0d expected 4 4 0", k, dones, extra);
    end
    nvec++;
    if (cyc != 11) begin
      nerr++; $display("FAIL b2b_cycles: got %0d expected 11", cyc);
    end
    for (int i = 0; i < 4; i++) model_apply(q_op[i], q_rd[i], q_rs1[i], q_rs2[i], q_imm[i]);
    check_regs("b2b_regs");
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_shl;
    test_mul_wrap;
    test_illegal;
    test_reset_mid_wb;
    test_back_to_back;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for the 16-bit logic unit.
- Accepts one register-to-register instruction per handshake and reads operands from an internal 8x16 register file.
- Drives bus1/bus2 plus exactly one one-hot operation strobe to the logic unit.
- In the following cycle asserts push/push_high and writes the logic unit's bus3 (and bus4 for MUL) back into the register file.

Parameters:
- NREGS, 8, register count; register address width is log2(NREGS) = 3.
- WIDTH, 16, datapath width; must match the logic unit bus width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- opcode  in  4  operation code (map below).
- rd  in  3  destination register.
- rs1  in  3  source register 1, driven onto bus1.
- rs2  in  3  source register 2, driven onto bus2.
- imm  in  16  immediate for LDI.
- op_strobe  out  11  one-hot to logic unit: [0]add [1]sub [2]inc [3]dec [4]mul [5]shr [6]shl [7]band [8]bor [9]bxor [10]bnegate.
- passthrough  out  1  to logic unit.
- push  out  1  to logic unit.
- push_high  out  1  to logic unit.
- bus1  out  16  operand A.
- bus2  out  16  operand B.
- bus3  in  16  result low word from logic unit.
- bus4  in  16  result high word from logic unit.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse with done for an illegal opcode.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async, rst_n low): state IDLE; all registers 0; op_strobe, passthrough, push, push_high, done and err 0; bus1/bus2 0; instr_ready 1. Reset mid-instruction abandons it with no writeback.
- Opcode map:
  - 0–10: ALU operation, maps to op_strobe bit of the same index.
  - 11: MOV (passthrough).
  - 12: LDI.
  - 13–15: illegal.
- instr_ready = (state == IDLE). An instruction is accepted on a rising edge with instr_valid && instr_ready; opcode, rd, rs1, rs2 and imm are latched on that edge.
- FSM: IDLE -> EXEC -> WB -> IDLE.
  - EXEC (1 cycle):
    - bus1 = reg[rs1], bus2 = reg[rs2], sampled from the register file at EXEC entry.
    - Exactly one op_strobe bit is high for ALU opcodes; the logic unit stores the result on the EXEC->WB edge.
    - MOV: passthrough=1 and no strobe; bus3 is written to reg[rd] on the same edge; done pulses in the next cycle; returns to IDLE, skipping WB.
    - LDI: no logic-unit activity; imm is written to reg[rd]; return to IDLE with done.
    - Illegal: no write; return to IDLE with done=1, err=1.
  - WB (1 cycle):
    - push=1; bus3 is written to reg[rd] at the WB edge.
    - MUL only: push_high=1 as well; bus4 is written to reg[(rd+1) mod 8], so 7 wraps to 0.
    - done pulses the cycle after WB.
- Latency (accept edge to done): ALU ops 3 cycles; MOV/LDI/illegal 2 cycles. instr_ready returns high in the same cycle as done.
- Back-to-back: a new instruction may be accepted in the done cycle. Because writeback precedes that cycle, read-after-write needs no forwarding.
- rd == rs1/rs2 is legal: operands were already driven in EXEC.
- All outputs to the logic unit are 0 outside their assigned cycle; op_strobe is never multi-hot.
- bus1/bus2 hold their last values outside EXEC; no requirement is placed on them there.
- dbg_data reflects writes from the edge following the write.
- Width rules: no overflow/carry flag. MUL is full 32-bit; all other ops take the low 16 bits only.

Test Plan:
- Reset with rst_n=0 mid-WB -> push deasserts immediately; all regs read 0 via dbg; instr_ready=1.
- LDI r1=0x1234, LDI r2=0x0F0F, ADD r3=r1+r2 -> op_strobe=0x001 in EXEC, push in WB, r3=0x2143, done 3 cycles after accept.
- LDI r6=0x0100, MUL r7=r6*r6 -> push_high=1 in WB; r7=0x0000 and r0=0x0001 (rd+1 wrap).
- SUB r4=0x0000-0x0001 -> r4=0xFFFF; then SHL r5=r4<<4 (r2 holds 4) -> r5=0xFFF0.
- Opcode 14 -> err and done pulse together; no register changes; no op_strobe bit ever high.
- Hold instr_valid=1 continuously with a 4-instruction stream -> exactly one accept per IDLE, a MOV reading the prior rd sees the new value, and no instruction is dropped or duplicated.
